piece_mover: RTL and testbench

- Parametrised successor to the single-direction move blocks: one engine owns the active piece and serves LEFT, RIGHT, DOWN and SPAWN requests over a valid/ready handshake.
- Checks every move against both the board edges and the locked-cell board, not only the edges.
- Adds an internal gravity timer, lock signalling and game-over detection.
- Sits between the input/control FSM and the line-clear/render logic; drives the composite screen.

---
 rtl/piece_mover.sv | 196 +++++++++++++++++++
 tb/tb_piece_mover.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_mover.sv
// piece_mover: owns the active piece and serves LEFT/RIGHT/DOWN/SPAWN requests.
// An accepted request is latched with a board snapshot, checked for edge and
// board collisions for one cycle, then committed or rejected with a response
// pulse. Includes a gravity timer, lock signalling and sticky game-over.
module piece_mover #(
   parameter int COLS        = 10,
   parameter int ROWS        = 20,
   parameter int BOX         = 4,
   parameter int DROP_PERIOD = 50_000_000,
   parameter int RW          = $clog2(ROWS)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_op,
   input  logic [BOX*COLS-1:0]  spawn_shape,
   input  logic [ROWS*COLS-1:0] board_i,
   input  logic                 gravity_en,
   output logic                 resp_valid,
   output logic                 resp_ok,
   output logic                 lock_pulse,
   output logic                 piece_active,
   output logic [BOX*COLS-1:0]  piece_shape,
   output logic [RW-1:0]        piece_row,
   output logic [ROWS*COLS-1:0] screen_o,
   output logic                 game_over
);

   localparam int CW = (DROP_PERIOD > 1) ? $clog2(DROP_PERIOD) : 1;
   localparam logic [1:0]    OpLeft   = 2'd0;
   localparam logic [1:0]    OpRight  = 2'd1;
   localparam logic [1:0]    OpDown   = 2'd2;
   localparam logic [1:0]    OpSpawn  = 2'd3;
   localparam logic [RW-1:0] SpawnRow = RW'(ROWS - BOX);
   localparam logic [CW-1:0] DropLast = CW'(DROP_PERIOD - 1);

   typedef enum logic {StIdle, StCheck} state_t;

   state_t                state_q, state_d;
   logic [1:0]            op_q;
   logic [ROWS*COLS-1:0]  board_q;
   logic [BOX*COLS-1:0]   cand_shape_q, cand_shape_d;
   logic [RW-1:0]         cand_row_q, cand_row_d;
   logic [CW-1:0]         grav_cnt_q, grav_cnt_d;
   logic                  grav_pend_q, grav_pend_d;
   logic                  accept, accept_int;
   logic [1:0]            acc_op;
   logic                  edge_hit, collide, ok, lock, set_go;
   logic [ROWS*COLS-1:0]  screen_d;
   int                    chk_idx;

   // Places a box on an empty screen; box rows past the top are dropped.
   function automatic logic [ROWS*COLS-1:0] overlay(input logic [BOX*COLS-1:0] shape,
                                                    input logic [RW-1:0] row);
      logic [ROWS*COLS-1:0] o;
      int idx;
      o = '0;
      for (int r = 0; r < BOX; r++) begin
         idx = int'(row) + r;
         if (idx < ROWS) o[idx*COLS +: COLS] = shape[r*COLS +: COLS];
      end
      return o;
   endfunction

   // Handshake, gravity-request arbitration (external command wins) and next state.
   always_comb begin
      cmd_ready  = (state_q == StIdle);
      accept_int = cmd_ready && !cmd_valid && grav_pend_q && gravity_en;
      accept     = (cmd_ready && cmd_valid) || accept_int;
      acc_op     = cmd_valid ? cmd_op : OpDown;
      state_d    = state_q;
      case (state_q)
         StIdle:  if (accept) state_d = StCheck;
         StCheck: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Candidate position/shape formed at accept time from the current piece.
   always_comb begin
      cand_shape_d = piece_shape;
      cand_row_d   = piece_row;
      case (acc_op)
         OpLeft: begin
            for (int r = 0; r < BOX; r++)
               cand_shape_d[r*COLS +: COLS] = {piece_shape[r*COLS +: COLS-1], 1'b0};
         end
         OpRight: begin
            for (int r = 0; r < BOX; r++)
               cand_shape_d[r*COLS +: COLS] = {1'b0, piece_shape[r*COLS+1 +: COLS-1]};
         end
         OpDown:  cand_row_d = piece_row - RW'(1);
         default: begin
            cand_shape_d = spawn_shape;
            cand_row_d   = SpawnRow;
         end
      endcase
   end

   // Collision/edge check and resolution of the latched request.
   always_comb begin
      edge_hit = 1'b0;
      collide  = 1'b0;
      chk_idx  = 0;
      for (int r = 0; r < BOX; r++) begin
         chk_idx = int'(cand_row_q) + r;
         if (chk_idx < ROWS)
            collide = collide |
                      (|(cand_shape_q[r*COLS +: COLS] & board_q[chk_idx*COLS +: COLS]));
         if (op_q == OpLeft && piece_shape[r*COLS + COLS-1]) edge_hit = 1'b1;
         if (op_q == OpRight && piece_shape[r*COLS]) edge_hit = 1'b1;
      end
      // A DOWN from row 0 wraps the candidate row; edge_hit overrides it.
      if (op_q == OpDown && piece_row == '0) edge_hit = 1'b1;
      if (op_q == OpSpawn && piece_active) edge_hit = 1'b1;
      ok     = !game_over && (piece_active || op_q == OpSpawn) && !edge_hit && !collide;
      lock   = !game_over && piece_active && op_q == OpDown && !ok;
      set_go = !game_over && !piece_active && op_q == OpSpawn && collide;
      if (ok) screen_d = board_q | overlay(cand_shape_q, cand_row_q);
      else if (piece_active && !lock) screen_d = board_q | overlay(piece_shape, piece_row);
      else screen_d = board_q;
   end

   // Gravity timer: commits of DOWN/SPAWN restart it; disabled timer freezes.
   always_comb begin
      grav_cnt_d  = grav_cnt_q;
      grav_pend_d = grav_pend_q;
      if (accept_int) grav_pend_d = 1'b0;
      if (state_q == StCheck && ok && (op_q == OpDown || op_q == OpSpawn)) begin
         grav_cnt_d = '0;
      end else if (gravity_en) begin
         if (grav_cnt_q == DropLast) begin
            grav_cnt_d  = '0;
            grav_pend_d = 1'b1;
         end else begin
            grav_cnt_d = grav_cnt_q + CW'(1);
         end
      end
   end

   // State and gravity registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         grav_cnt_q  <= '0;
         grav_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         grav_cnt_q  <= grav_cnt_d;
         grav_pend_q <= grav_pend_d;
      end
   end

   // Request latch, piece registers, response pulses and the screen.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q         <= OpLeft;
         board_q      <= '0;
         cand_shape_q <= '0;
         cand_row_q   <= '0;
         resp_valid   <= 1'b0;
         resp_ok      <= 1'b0;
         lock_pulse   <= 1'b0;
         piece_active <= 1'b0;
         piece_shape  <= '0;
         piece_row    <= '0;
         screen_o     <= '0;
         game_over    <= 1'b0;
      end else begin
         resp_valid <= 1'b0;
         resp_ok    <= 1'b0;
         lock_pulse <= 1'b0;
         if (accept) begin
            op_q         <= acc_op;
            board_q      <= board_i;
            cand_shape_q <= cand_shape_d;
            cand_row_q   <= cand_row_d;
         end
         if (state_q == StCheck) begin
            resp_valid <= 1'b1;
            resp_ok    <= ok;
            lock_pulse <= lock;
            screen_o   <= screen_d;
            if (ok) begin
               piece_shape <= cand_shape_q;
               piece_row   <= cand_row_q;
               if (op_q == OpSpawn) piece_active <= 1'b1;
            end
            if (lock) piece_active <= 1'b0;
            if (set_go) game_over <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_piece_mover.sv
// Self-checking bench for piece_mover: directed scenarios plus randomized
// requests compared against a row-array model of the game rules.
module tb_piece_mover;

   localparam int COLS = 10;
   localparam int ROWS = 20;
   localparam int BOX  = 4;
   localparam int DP   = 8;
   localparam int RW   = $clog2(ROWS);

   logic                 clk = 1'b0;
   logic                 reset, cmd_valid, cmd_ready, gravity_en;
   logic [1:0]           cmd_op;
   logic [BOX*COLS-1:0]  spawn_shape, piece_shape;
   logic [ROWS*COLS-1:0] board_i, screen_o;
   logic                 resp_valid, resp_ok, lock_pulse, piece_active, game_over;
   logic [RW-1:0]        piece_row;

   piece_mover #(.COLS(COLS), .ROWS(ROWS), .BOX(BOX), .DROP_PERIOD(DP), .RW(RW)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .spawn_shape(spawn_shape), .board_i(board_i),
      .gravity_en(gravity_en), .resp_valid(resp_valid), .resp_ok(resp_ok),
      .lock_pulse(lock_pulse), .piece_active(piece_active), .piece_shape(piece_shape),
      .piece_row(piece_row), .screen_o(screen_o), .game_over(game_over)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model state
   bit                m_active, m_go;
   int                m_row;
   logic [COLS-1:0]   m_shape [BOX];
   bit                e_ok, e_lock;

   // Observed values of the last transaction
   logic                 s_mid_ready, s_mid_valid, s_valid, s_ok, s_lock, s_active, s_go, s_ready;
   logic [BOX*COLS-1:0]  s_shape;
   logic [RW-1:0]        s_row;
   logic [ROWS*COLS-1:0] s_screen;

   function automatic logic [COLS-1:0] rnd_row(input bit sparse);
      if (sparse) return COLS'($urandom & $urandom & $urandom);
      return COLS'($urandom);
   endfunction

   function automatic logic [ROWS*COLS-1:0] rnd_board(input bit sparse, input bit top_empty);
      logic [ROWS*COLS-1:0] b;
      for (int y = 0; y < ROWS; y++)
         b[y*COLS +: COLS] = (top_empty && y >= ROWS - BOX) ? '0 : rnd_row(sparse);
      return b;
   endfunction

   function automatic bit fits(input logic [COLS-1:0] c [BOX], input int crow,
                               input logic [ROWS*COLS-1:0] brd);
      for (int r = 0; r < BOX; r++) begin
         if (crow + r < ROWS && (c[r] & brd[(crow+r)*COLS +: COLS]) != '0) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [BOX*COLS-1:0] exp_shape();
      logic [BOX*COLS-1:0] f;
      for (int r = 0; r < BOX; r++) f[r*COLS +: COLS] = m_shape[r];
      return f;
   endfunction

   function automatic logic [ROWS*COLS-1:0] exp_screen(input logic [ROWS*COLS-1:0] brd);
      logic [ROWS*COLS-1:0] s;
      logic [COLS-1:0]      row;
      for (int y = 0; y < ROWS; y++) begin
         row = brd[y*COLS +: COLS];
         if (m_active && y >= m_row && y < m_row + BOX) row = row | m_shape[y - m_row];
         s[y*COLS +: COLS] = row;
      end
      return s;
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_go     = 1'b0;
      m_row    = 0;
      for (int r = 0; r < BOX; r++) m_shape[r] = '0;
   endtask

   task automatic model_req(input logic [1:0] op, input logic [BOX*COLS-1:0] sp,
                            input logic [ROWS*COLS-1:0] brd);
      logic [COLS-1:0] cand [BOX];
      int crow;
      bit legal;
      e_ok   = 1'b0;
      e_lock = 1'b0;
      if (m_go) return;
      if (op == 2'd3) begin
         if (m_active) return;
         for (int r = 0; r < BOX; r++) cand[r] = sp[r*COLS +: COLS];
         if (fits(cand, ROWS - BOX, brd)) begin
            m_active = 1'b1;
            m_row    = ROWS - BOX;
            m_shape  = cand;
            e_ok     = 1'b1;
         end else begin
            m_go = 1'b1;
         end
         return;
      end
      if (!m_active) return;
      legal = 1'b1;
      crow  = (op == 2'd2) ? m_row - 1 : m_row;
      for (int r = 0; r < BOX; r++) begin
         case (op)
            2'd0: begin
               if (m_shape[r][COLS-1]) legal = 1'b0;
               cand[r] = m_shape[r] << 1;
            end
            2'd1: begin
               if (m_shape[r][0]) legal = 1'b0;
               cand[r] = m_shape[r] >> 1;
            end
            default: cand[r] = m_shape[r];
         endcase
      end
      if (crow < 0) legal = 1'b0;
      else if (!fits(cand, crow, brd)) legal = 1'b0;
      if (legal) begin
         m_shape = cand;
         m_row   = crow;
         e_ok    = 1'b1;
      end else if (op == 2'd2) begin
         e_lock   = 1'b1;
         m_active = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      cmd_valid   = 1'b0;
      cmd_op      = 2'd0;
      gravity_en  = 1'b0;
      board_i     = '0;
      spawn_shape = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   // Drive one request from IDLE; sample the CHECK cycle and the response cycle.
   task automatic issue(input logic [1:0] op, input logic [BOX*COLS-1:0] sp,
                        input logic [ROWS*COLS-1:0] brd);
      cmd_valid   = 1'b1;
      cmd_op      = op;
      spawn_shape = sp;
      board_i     = brd;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      board_i   = rnd_board(1'b0, 1'b0);
      for (int r = 0; r < BOX; r++) spawn_shape[r*COLS +: COLS] = rnd_row(1'b0);
      s_mid_ready = cmd_ready;
      s_mid_valid = resp_valid;
      model_req(op, sp, brd);
      @(posedge clk);
      #1;
      s_valid  = resp_valid;
      s_ok     = resp_ok;
      s_lock   = lock_pulse;
      s_active = piece_active;
      s_shape  = piece_shape;
      s_row    = piece_row;
      s_screen = screen_o;
      s_go     = game_over;
      s_ready  = cmd_ready;
   endtask

   task automatic test_reset();
      do_reset();
      tests++;
      if ({cmd_ready, resp_valid, resp_ok, lock_pulse, piece_active, game_over} !== 6'b100000)
      begin
         fails++;
         $display("FAIL reset_flags: got %b want 100000",
                  {cmd_ready, resp_valid, resp_ok, lock_pulse, piece_active, game_over});
      end
      tests++;
      if (piece_shape !== '0 || piece_row !== '0 || screen_o !== '0) begin
         fails++;
         $display("FAIL reset_regs: shape=%h row=%0d screen=%h want zeros",
                  piece_shape, piece_row, screen_o);
      end
   endtask

   task automatic test_spawn_right();
      logic [BOX*COLS-1:0] sp;
      logic [COLS-1:0]     want_r0 [3];
      bit                  want_ok [3];
      want_r0 = '{10'h01E, 10'h00F, 10'h00F};
      want_ok = '{1'b1, 1'b1, 1'b0};
      do_reset();
      sp = '0;
      sp[COLS-1:0] = 10'h03C;
      issue(2'd3, sp, '0);
      tests++;
      if (s_valid !== 1'b1 || s_ok !== 1'b1 || s_active !== 1'b1) begin
         fails++;
         $display("FAIL spawn_resp: valid=%b ok=%b active=%b want 1 1 1", s_valid, s_ok, s_active);
      end
      tests++;
      if (s_row !== RW'(16) || s_screen[16*COLS +: COLS] !== 10'h03C) begin
         fails++;
         $display("FAIL spawn_pos: row=%0d screen16=%h want 16 03c",
                  s_row, s_screen[16*COLS +: COLS]);
      end
      for (int i = 0; i < 3; i++) begin
         issue(2'd1, '0, '0);
         tests++;
         if (s_valid !== 1'b1 || s_ok !== want_ok[i] || s_lock !== 1'b0 ||
             s_shape[COLS-1:0] !== want_r0[i]) begin
            fails++;
            $display("FAIL right_%0d: valid=%b ok=%b lock=%b row0=%h want 1 %b 0 %h",
                     i, s_valid, s_ok, s_lock, s_shape[COLS-1:0], want_ok[i], want_r0[i]);
         end
      end
   endtask

   // Continues from the piece left at row 16 by test_spawn_right.
   task automatic test_lock();
      logic [ROWS*COLS-1:0] brd;
      brd = '0;
      brd[15*COLS +: COLS] = 10'h03C;
      issue(2'd2, '0, brd);
      tests++;
      if (s_ok !== 1'b0 || s_lock !== 1'b1 || s_active !== 1'b0) begin
         fails++;
         $display("FAIL lock_resp: ok=%b lock=%b active=%b want 0 1 0", s_ok, s_lock, s_active);
      end
      tests++;
      if (s_screen !== brd) begin
         fails++;
         $display("FAIL lock_screen: got %h want %h", s_screen, brd);
      end
      @(posedge clk);
      #1;
      tests++;
      if (lock_pulse !== 1'b0 || resp_valid !== 1'b0) begin
         fails++;
         $display("FAIL lock_width: lock=%b valid=%b one cycle later, want 0 0",
                  lock_pulse, resp_valid);
      end
   endtask

   task automatic test_reset_mid_check();
      logic [BOX*COLS-1:0] sp;
      do_reset();
      sp = '0;
      sp[COLS-1:0] = 10'h018;
      issue(2'd3, sp, '0);
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      board_i   = '0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      reset     = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      tests++;
      if (resp_valid !== 1'b0 || piece_active !== 1'b0 || piece_shape !== '0 ||
          cmd_ready !== 1'b1 || screen_o !== '0) begin
         fails++;
         $display("FAIL reset_mid: valid=%b active=%b shape=%h ready=%b want 0 0 0 1",
                  resp_valid, piece_active, piece_shape, cmd_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [BOX*COLS-1:0] sp;
      logic [3:0]          pat;
      logic [COLS-1:0]     r0_first;
      do_reset();
      sp = '0;
      sp[COLS-1:0] = 10'h03C;
      issue(2'd3, sp, '0);
      board_i   = '0;
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      @(posedge clk);
      #1;
      cmd_op = 2'd0;
      pat    = '0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         pat[3-i] = resp_valid;
         if (i == 0) r0_first = piece_shape[COLS-1:0];
         if (i == 1) cmd_valid = 1'b0;
      end
      tests++;
      if (pat !== 4'b1010 || r0_first !== 10'h01E || piece_shape[COLS-1:0] !== 10'h03C) begin
         fails++;
         $display("FAIL back_to_back: pulses=%b first=%h final=%h want 1010 01e 03c",
                  pat, r0_first, piece_shape[COLS-1:0]);
      end
   endtask

   task automatic test_gravity();
      logic [BOX*COLS-1:0] sp;
      int cyc, last, npulse;
      do_reset();
      sp = '0;
      sp[COLS-1:0] = 10'h00F;
      issue(2'd3, sp, '0);
      board_i    = '0;
      gravity_en = 1'b1;
      cyc        = 0;
      last       = 0;
      npulse     = 0;
      while (cyc < 17 * (DP + 4) + DP) begin
         @(posedge clk);
         #1;
         cyc++;
         if (resp_valid === 1'b1) begin
            model_req(2'd2, '0, '0);
            tests++;
            if (resp_ok !== e_ok || lock_pulse !== e_lock || piece_row !== m_row[RW-1:0]) begin
               fails++;
               $display("FAIL gravity_step_%0d: ok=%b lock=%b row=%0d want %b %b %0d",
                        npulse, resp_ok, lock_pulse, piece_row, e_ok, e_lock, m_row);
            end
            if (npulse > 0) begin
               tests++;
               if (cyc - last < DP || cyc - last > DP + 3) begin
                  fails++;
                  $display("FAIL gravity_gap_%0d: got %0d cycles want %0d..%0d",
                           npulse, cyc - last, DP, DP + 3);
               end
            end
            last = cyc;
            npulse++;
            if (e_lock) break;
         end
      end
      gravity_en = 1'b0;
      tests++;
      if (npulse != 17) begin
         fails++;
         $display("FAIL gravity_count: got %0d responses want 17", npulse);
      end
   endtask

   task automatic test_gravity_vs_cmd();
      logic [BOX*COLS-1:0] sp;
      logic [5:0]          pat;
      logic [COLS-1:0]     r0_a;
      logic [RW-1:0]       row_a, row_b;
      do_reset();
      sp = '0;
      sp[COLS-1:0] = 10'h00F;
      issue(2'd3, sp, '0);
      board_i    = '0;
      gravity_en = 1'b1;
      repeat (DP - 1) @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_op    = 2'd0;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      pat   = '0;
      r0_a  = '0;
      row_a = '0;
      row_b = '0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         pat[5-i] = resp_valid;
         if (i == 0) begin
            r0_a  = piece_shape[COLS-1:0];
            row_a = piece_row;
         end
         if (i == 2) row_b = piece_row;
      end
      gravity_en = 1'b0;
      tests++;
      if (pat !== 6'b101000) begin
         fails++;
         $display("FAIL grav_vs_cmd_timing: pulses=%b want 101000", pat);
      end
      tests++;
      if (r0_a !== 10'h01E || row_a !== RW'(16) || row_b !== RW'(15)) begin
         fails++;
         $display("FAIL grav_vs_cmd_order: row0=%h rowA=%0d rowB=%0d want 01e 16 15",
                  r0_a, row_a, row_b);
      end
   endtask

   task automatic test_game_over();
      logic [BOX*COLS-1:0]  sp;
      logic [ROWS*COLS-1:0] brd;
      do_reset();
      sp  = '0;
      brd = '0;
      sp[COLS-1:0]         = 10'h200;
      brd[16*COLS +: COLS] = 10'h200;
      issue(2'd3, sp, brd);
      tests++;
      if (s_valid !== 1'b1 || s_ok !== 1'b0 || s_go !== 1'b1 || s_active !== 1'b0) begin
         fails++;
         $display("FAIL go_spawn: valid=%b ok=%b go=%b active=%b want 1 0 1 0",
                  s_valid, s_ok, s_go, s_active);
      end
      issue(2'd1, '0, '0);
      tests++;
      if (s_valid !== 1'b1 || s_ok !== 1'b0 || s_go !== 1'b1) begin
         fails++;
         $display("FAIL go_sticky: valid=%b ok=%b go=%b want 1 0 1", s_valid, s_ok, s_go);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      tests++;
      if (game_over !== 1'b0 || cmd_ready !== 1'b1) begin
         fails++;
         $display("FAIL go_reset: go=%b ready=%b want 0 1", game_over, cmd_ready);
      end
   endtask

   task automatic test_random();
      logic [1:0]           op;
      logic [BOX*COLS-1:0]  sp;
      logic [ROWS*COLS-1:0] brd;
      do_reset();
      for (int it = 0; it < 80; it++) begin
         op = 2'($urandom_range(0, 3));
         if (!m_active && $urandom_range(0, 1) == 1) op = 2'd3;
         for (int r = 0; r < BOX; r++) sp[r*COLS +: COLS] = COLS'($urandom & $urandom);
         brd = rnd_board(1'b1, $urandom_range(0, 3) != 0);
         issue(op, sp, brd);
         tests++;
         if (s_mid_ready !== 1'b0 || s_mid_valid !== 1'b0 || s_valid !== 1'b1 ||
             s_ready !== 1'b1) begin
            fails++;
            $display("FAIL rnd_hs_%0d: mid_ready=%b mid_valid=%b valid=%b ready=%b want 0 0 1 1",
                     it, s_mid_ready, s_mid_valid, s_valid, s_ready);
         end
         tests++;
         if (s_ok !== e_ok || s_lock !== e_lock || s_active !== m_active || s_go !== m_go) begin
            fails++;
            $display("FAIL rnd_flags_%0d op=%0d: ok=%b lock=%b act=%b go=%b want %b %b %b %b",
                     it, op, s_ok, s_lock, s_active, s_go, e_ok, e_lock, m_active, m_go);
         end
         tests++;
         if (s_shape !== exp_shape() || s_row !== m_row[RW-1:0]) begin
            fails++;
            $display("FAIL rnd_piece_%0d op=%0d: shape=%h row=%0d want %h %0d",
                     it, op, s_shape, s_row, exp_shape(), m_row);
         end
         tests++;
         if (s_screen !== exp_screen(brd)) begin
            fails++;
            $display("FAIL rnd_screen_%0d op=%0d: got %h want %h",
                     it, op, s_screen, exp_screen(brd));
         end
         if (m_go) do_reset();
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached after %0d tests", tests);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_spawn_right();
      test_lock();
      test_reset_mid_check();
      test_back_to_back();
      test_gravity();
      test_gravity_vs_cmd();
      test_game_over();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
